// File: rtl/uart_tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e          : arbiter FSM states
//   - LOAD_LEN             : number of cycles TxEn is held per byte
//   - DW_DEFAULT           : default requester byte width
//   - TIMEOUT_CYC_DEFAULT  : default TxDone watchdog limit (clock cycles)
//   - idx_width()          : width of an index into n items (minimum 1)
// ---------------------------------------------------------------------------
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    WAIT_CLR  = 2'd3
  } arb_state_e;

  localparam int LOAD_LEN            = 2;
  localparam int DW_DEFAULT          = 8;
  localparam int TIMEOUT_CYC_DEFAULT = 65535;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. The search starts one position
// after the previous winner and wraps modulo NREQ; the first requesting
// position found wins.
// Ports:
//   req          in   NREQ  request vector
//   last_winner  in   IW    index of the previous winner
//   grant        out  NREQ  one-hot winner (all zero when req == 0)
//   index        out  IW    encoded winner (0 when req == 0)
// ---------------------------------------------------------------------------
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);

  always_comb begin
    int   cand;
    logic found;
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    // Offsets 1..NREQ: the previous winner is visited last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_winner) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && req[cand[IW-1:0]]) begin
        found                  = 1'b1;
        grant[cand[IW-1:0]]    = 1'b1;
        index                  = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NREQ requesters using round-robin
// arbitration. A winner is granted for one cycle, its byte is registered onto
// TxData and TxEn is held for LOAD_LEN cycles; the arbiter then waits for the
// transmitter's TxDone level to rise and fall again (through a 2-flop
// synchronizer) before accepting the next request.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a TxDone watchdog.
// The counter runs through WAIT_DONE and WAIT_CLR; reaching TIMEOUT_CYC-1
// aborts to IDLE and pulses Timeout for one cycle.
//
// Ports:
//   Clk      in   1        clock, rising edge
//   Rst      in   1        synchronous active-high reset
//   Req      in   NREQ     per-requester request, held until its Gnt
//   Data     in   NREQ*DW  requester bytes, requester i at [i*DW +: DW]
//   Gnt      out  NREQ     one-hot one-cycle acceptance pulse
//   Busy     out  1        high whenever the FSM is not in IDLE
//   TxEn     out  1        transmitter start, high for both LOAD cycles
//   TxData   out  DW       byte presented to the transmitter
//   TxDone   in   1        transmitter completion level (asynchronous)
//   Timeout  out  1        watchdog abort pulse (UART_TX_ARB_TIMEOUT_EN only)
//
// States:
//   IDLE      | no transfer; grants the next requester when any Req is high
//   LOAD      | TxEn high for LOAD_LEN cycles, Gnt valid in the first
//   WAIT_DONE | waiting for synchronized TxDone = 1
//   WAIT_CLR  | waiting for synchronized TxDone = 0
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DW          = DW_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ*DW-1:0]   Data,
  output logic [NREQ-1:0]      Gnt,
  output logic                 Busy,
  output logic                 TxEn,
  output logic [DW-1:0]        TxData,
  input  logic                 TxDone
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                 Timeout
`endif
);

  localparam int IW  = idx_width(NREQ);
  localparam int LCW = idx_width(LOAD_LEN);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
  end

  arb_state_e       state;
  logic [IW-1:0]    last_winner;
  logic [LCW-1:0]   load_cnt;
  logic             done_s1;
  logic             done_s2;

  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic [DW-1:0]    sel_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WDW = idx_width(TIMEOUT_CYC);
  logic [WDW-1:0]   wd_cnt;
  logic             wd_expired;

  assign wd_expired = (wd_cnt == WDW'(TIMEOUT_CYC - 1));
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req         (Req),
    .last_winner (last_winner),
    .grant       (pick_gnt),
    .index       (pick_idx)
  );

  assign sel_data = Data[int'(pick_idx)*DW +: DW];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      last_winner <= IW'(NREQ - 1);
      load_cnt    <= '0;
      done_s1     <= 1'b0;
      done_s2     <= 1'b0;
      Gnt         <= '0;
      Busy        <= 1'b0;
      TxEn        <= 1'b0;
      TxData      <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      Timeout     <= 1'b0;
`endif
    end else begin
      done_s1 <= TxDone;
      done_s2 <= done_s1;
      Gnt     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      Timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Req is only looked at here, so changes during a transfer
          // are simply evaluated on the next IDLE cycle.
          if (|Req) begin
            state       <= LOAD;
            Gnt         <= pick_gnt;
            TxData      <= sel_data;
            last_winner <= pick_idx;
            TxEn        <= 1'b1;
            Busy        <= 1'b1;
            load_cnt    <= '0;
          end
        end

        LOAD: begin
          if (load_cnt == LCW'(LOAD_LEN - 1)) begin
            state <= WAIT_DONE;
            TxEn  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end else begin
            load_cnt <= load_cnt + LCW'(1);
          end
        end

        WAIT_DONE: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          if (wd_expired) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
            if (done_s2) begin
              state <= WAIT_CLR;
            end
          end
`else
          if (done_s2) begin
            state <= WAIT_CLR;
          end
`endif
        end

        WAIT_CLR: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          if (wd_expired) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
            if (!done_s2) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
`else
          if (!done_s2) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
`endif
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          TxEn  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NREQ=4, DW=8, TIMEOUT_CYC=16).
// A transfer-level model predicts Gnt/TxEn/TxData/Busy(/Timeout) from the
// inputs every cycle; directed scenarios add literal expectations on grant
// order, byte values and latencies. The watchdog scenario is built only when
// UART_TX_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b1;
  logic [NREQ-1:0]      Req = '0;
  logic [NREQ*DW-1:0]   Data = '0;
  logic [NREQ-1:0]      Gnt;
  logic                 Busy;
  logic                 TxEn;
  logic [DW-1:0]        TxData;
  logic                 TxDone = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic                 Timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Req    (Req),
    .Data   (Data),
    .Gnt    (Gnt),
    .Busy   (Busy),
    .TxEn   (TxEn),
    .TxData (TxData),
    .TxDone (TxDone)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .Timeout(Timeout)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Transfer-level model
  // ------------------------------------------------------------------
  logic            m_busy     = 1'b0;
  int              m_load_left = 0;   // TxEn cycles still to come
  logic            m_seen_done = 1'b0;
  logic [NREQ-1:0] m_gnt      = '0;
  logic [DW-1:0]   m_txdata   = '0;
  int              m_last     = NREQ - 1;
  logic [1:0]      m_sync     = '0;   // [1] is the value the arbiter acts on
  int              m_wd       = 0;
  logic            m_timeout  = 1'b0;

  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic done_now;
    int   w;
    if (Rst) begin
      m_busy = 0; m_load_left = 0; m_seen_done = 0; m_gnt = '0; m_txdata = '0;
      m_last = NREQ - 1; m_sync = '0; m_wd = 0; m_timeout = 0;
      return;
    end
    done_now  = m_sync[1];
    m_sync    = {m_sync[0], TxDone};
    m_gnt     = '0;
    m_timeout = 0;
    if (!m_busy) begin
      if (Req != '0) begin
        w           = rr_next(Req, m_last);
        m_gnt       = NREQ'(1) << w;
        m_txdata    = Data[w*DW +: DW];
        m_last      = w;
        m_busy      = 1;
        m_load_left = 2;
        m_seen_done = 0;
      end
    end else if (m_load_left > 0) begin
      m_load_left--;
      m_wd = 0;
    end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (m_wd == TO - 1) begin
        m_busy    = 0;
        m_timeout = 1;
      end else begin
        m_wd++;
        if (!m_seen_done) begin
          if (done_now) m_seen_done = 1;
        end else if (!done_now) begin
          m_busy = 0;
        end
      end
`else
      if (!m_seen_done) begin
        if (done_now) m_seen_done = 1;
      end else if (!done_now) begin
        m_busy = 0;
      end
`endif
    end
  endtask

  // ------------------------------------------------------------------
  // Per-cycle compare, grant log, automatic Req drop after Gnt
  // ------------------------------------------------------------------
  int              gnt_log[$];
  int              txen_pulses = 0;
  logic            txen_prev   = 1'b0;
  logic [NREQ-1:0] sticky      = '0;

  always @(posedge Clk) begin
    model_step();
    #1;
    check("gnt",    Gnt,    m_gnt);
    check("txen",   TxEn,   (m_busy && m_load_left > 0));
    check("txdata", TxData, m_txdata);
    check("busy",   Busy,   m_busy);
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("timeout", Timeout, m_timeout);
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (Gnt[i] === 1'b1) gnt_log.push_back(i);
    end
    if (TxEn === 1'b1 && !txen_prev) txen_pulses++;
    txen_prev = TxEn;
    Req = Req & ~(Gnt & ~sticky);
  end

  // Simple transmitter: TxDone high for 4 cycles, a few cycles after TxEn.
  logic auto_tx = 1'b1;
  int   tx_cnt  = 0;

  always @(negedge Clk) begin
    if (auto_tx) begin
      if (TxEn === 1'b1 && tx_cnt == 0) tx_cnt = 8;
      else if (tx_cnt > 0) tx_cnt--;
      TxDone = (tx_cnt > 0 && tx_cnt <= 4);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  // ------------------------------------------------------------------
  // Directed helpers
  // ------------------------------------------------------------------
  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic wait_grant(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Gnt == '0 && n < max_cyc);
    check("grant_seen", (Gnt != '0), 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (Busy !== 1'b0 && n < max_cyc) begin
      @(negedge Clk);
      n++;
    end
    check("idle_reached", Busy, 0);
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  initial begin
    int n;
    Data = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
    repeat (3) @(negedge Clk);
    check("rst_busy",   Busy,   0);
    check("rst_txen",   TxEn,   0);
    check("rst_txdata", TxData, 8'h00);
    check("rst_gnt",    Gnt,    4'b0000);
    Rst = 1'b0;

    // Single requester
    @(negedge Clk);
    Req = 4'b0001;
    wait_grant(20);
    check("single_gnt",    Gnt,    4'b0001);
    check("single_txdata", TxData, 8'hA5);
    check("single_txen1",  TxEn,   1);
    @(negedge Clk);
    check("single_gnt_off", Gnt,  4'b0000);
    check("single_txen2",   TxEn, 1);
    @(negedge Clk);
    check("single_txen_end", TxEn, 0);
    wait_idle(60);
    check("single_count", gnt_log.size(), 1);
    check("single_txdata_hold", TxData, 8'hA5);

    // All requesters from reset: order 0,1,2,3 and four TxEn pulses
    do_reset();
    gnt_log.delete();
    txen_pulses = 0;
    Req = 4'b1111;
    n = 0;
    while (!(gnt_log.size() == 4 && Busy === 1'b0) && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check("all_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) check("all_order", gnt_log[i], i);
    check("all_txen_pulses", txen_pulses, 4);

    // Fairness: 0 and 2 both keep requesting
    gnt_log.delete();
    sticky = 4'b0101;
    Req    = 4'b0101;
    n = 0;
    while (gnt_log.size() < 4 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    Req    = 4'b0000;
    sticky = 4'b0000;
    check("fair_count", gnt_log.size(), 4);
    if (gnt_log.size() >= 4) begin
      check("fair_g0", gnt_log[0], 0);
      check("fair_g1", gnt_log[1], 2);
      check("fair_g2", gnt_log[2], 0);
      check("fair_g3", gnt_log[3], 2);
    end
    wait_idle(60);

    // Withdrawn request: Req[1] pulses for one cycle during a transfer
    gnt_log.delete();
    @(negedge Clk);
    Req = 4'b0001;
    wait_grant(20);
    @(negedge Clk);
    check("withdraw_busy", Busy, 1);
    Req = Req | 4'b0010;
    @(negedge Clk);
    Req = Req & 4'b1101;
    wait_idle(60);
    repeat (5) @(negedge Clk);
    check("withdraw_count", gnt_log.size(), 1);
    if (gnt_log.size() >= 1) check("withdraw_who", gnt_log[0], 0);

    // Reset during WAIT_DONE
    gnt_log.delete();
    Req = 4'b0100;
    wait_grant(20);
    check("mid_gnt", Gnt, 4'b0100);
    n = 0;
    while (TxEn === 1'b1 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    check("mid_in_wait", Busy, 1);
    Rst = 1'b1;
    @(negedge Clk);
    check("mid_busy",   Busy,   0);
    check("mid_txen",   TxEn,   0);
    check("mid_txdata", TxData, 8'h00);
    Rst = 1'b0;
    Req = 4'b1001;
    wait_grant(20);
    check("mid_next_gnt", Gnt, 4'b0001);
    n = 0;
    while (!(gnt_log.size() == 3 && Busy === 1'b0) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("mid_log", gnt_log.size(), 3);
    if (gnt_log.size() >= 3) check("mid_then_3", gnt_log[2], 3);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog with TxDone stuck low
    @(negedge Clk);
    auto_tx = 1'b0;
    TxDone  = 1'b0;
    Req     = 4'b0010;
    wait_grant(20);
    n = 0;
    while (TxEn === 1'b1 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    n = 0;
    while (Timeout !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("wd_latency", n, 16);
    check("wd_idle", Busy, 0);
    @(negedge Clk);
    check("wd_pulse_end", Timeout, 0);
`endif

    repeat (3) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
